// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared router flit, port-status and output-unit state types
package router_pkg;

    localparam int NUM_OF_FLITS = 8;
    localparam int FLIT_DATA_W  = 16;

    typedef enum logic [1:0] {
        HEAD_FLIT = 2'd0,
        BODY_FLIT = 2'd1,
        TAIL_FLIT = 2'd2
    } FLIT_TYPE_t;

    // valid sits in the MSB so a zero word is always an empty slot
    typedef struct packed {
        logic                   valid;
        FLIT_TYPE_t             flit_type;
        logic [FLIT_DATA_W-1:0] data;
    } FLIT_t;

    localparam int FLIT_SIZE = $bits(FLIT_t);

    typedef enum logic {
        PORT_FREE     = 1'b0,
        PORT_OCCUPIED = 1'b1
    } PORT_STATUS_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        REQ     = 2'd2,
        SEND    = 2'd3
    } OUT_STATE_t;

    function automatic FLIT_t invalid_flit();
        invalid_flit = '0;
    endfunction

endpackage

// File: rtl/sfifo.sv
// rtl/sfifo.sv - synchronous single-clock FIFO with show-ahead read data
module sfifo #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              do_wr, do_rd;

    assign do_wr = wr_en_i && !full_o;
    assign do_rd = rd_en_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign full_o    = count_q[ADDR_W];
    assign empty_o   = (count_q == '0);

endmodule

// File: rtl/output_unit.sv
// rtl/output_unit.sv - router output unit: collect packet, request downstream, stream it out (OUTPUT_UNIT_TIMEOUT_EN adds ack-timeout retry)
module output_unit
    import router_pkg::*;
#(
    parameter int DEPTH       = NUM_OF_FLITS,
    parameter int out_id      = 0,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  FLIT_t        i_flit,
    output logic         o_ready,
    output FLIT_t        o_flit,
    output logic         o_downstream_req,
    input  logic         i_transmit_ack,
    output PORT_STATUS_t o_port_status,
    output logic         o_retry
);

    localparam int AW = $clog2(DEPTH);

    OUT_STATE_t           state_q, state_d;
    FLIT_t                o_flit_q, o_flit_d;
    logic                 req_q, req_d;
    logic                 fifo_full, fifo_empty, fifo_rd;
    logic [FLIT_SIZE-1:0] fifo_rd_data;
    FLIT_t                head_flit;
    logic                 accept, ack_seen, timeout;

    assign o_ready   = ((state_q == IDLE) || (state_q == COLLECT)) && !fifo_full;
    assign accept    = i_flit.valid && o_ready;
    assign head_flit = FLIT_t'(fifo_rd_data);
    // a grant only counts while the request is actually visible downstream
    assign ack_seen  = (state_q == REQ) && req_q && i_transmit_ack;

    sfifo #(
        .WIDTH  (FLIT_SIZE),
        .ADDR_W (AW)
    ) u_buf (
        .clk       (clk),
        .rst_n     (~reset),
        .wr_en_i   (accept),
        .wr_data_i (i_flit),
        .rd_en_i   (fifo_rd),
        .rd_data_o (fifo_rd_data),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

`ifdef OUTPUT_UNIT_TIMEOUT_EN
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       retry_q;

    assign timeout = (state_q == REQ) && req_q && !i_transmit_ack
                     && ((wait_cnt_q + 8'd1) == 8'(ACK_TIMEOUT));

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if ((state_q != REQ) || timeout || i_transmit_ack) wait_cnt_d = '0;
        else if (req_q)                                   wait_cnt_d = wait_cnt_q + 8'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_q <= '0;
            retry_q    <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            retry_q    <= timeout;
        end
    end

    assign o_retry = retry_q;
`else
    assign timeout = 1'b0;
    assign o_retry = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        o_flit_d = invalid_flit();
        fifo_rd  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) state_d = (i_flit.flit_type == TAIL_FLIT) ? REQ : COLLECT;
            end
            COLLECT: begin
                if (accept && (i_flit.flit_type == TAIL_FLIT)) state_d = REQ;
            end
            REQ: begin
                if (ack_seen) begin
                    state_d        = SEND;
                    fifo_rd        = 1'b1;
                    o_flit_d       = head_flit;
                    o_flit_d.valid = 1'b1;
                end
            end
            SEND: begin
                // the buffer only ever holds one packet, so empty means the tail is out
                if (!fifo_empty) begin
                    fifo_rd        = 1'b1;
                    o_flit_d       = head_flit;
                    o_flit_d.valid = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        req_d = (state_d == REQ) && !timeout;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            o_flit_q <= invalid_flit();
            req_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            o_flit_q <= o_flit_d;
            req_q    <= req_d;
        end
    end

    assign o_flit           = o_flit_q;
    assign o_downstream_req = req_q;
    assign o_port_status    = (state_q == IDLE) ? PORT_FREE : PORT_OCCUPIED;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset && (state_q == COLLECT) && fifo_full && i_flit.valid)
            $error("output_unit %0d: packet exceeds DEPTH=%0d", out_id, DEPTH);
    end
`endif

endmodule

// File: doc/output_unit.md
OUTPUT_UNIT -- requirements
Module: output_unit

Interface
REQ-001 SHALL have parameter DEPTH, default NUM_OF_FLITS; packet buffer depth in flits, power of two.
REQ-002 SHALL have parameter out_id, default 0; output port index, used only in messages.
REQ-003 SHALL have parameter ACK_TIMEOUT, default 16; ack-wait cycles before retry; used only when OUTPUT_UNIT_TIMEOUT_EN is defined.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 i_flit  input  FLIT_t (FLIT_SIZE)  flit from crossbar; MSB set marks it valid.
REQ-007 o_ready  output  1  unit accepts a crossbar flit this cycle.
REQ-008 o_flit  output  FLIT_t  flit to the downstream input unit; MSB set marks it valid.
REQ-009 o_downstream_req  output  1  request to the downstream port.
REQ-010 i_transmit_ack  input  1  downstream grant.
REQ-011 o_port_status  output  PORT_STATUS_t  PORT_FREE in IDLE, else PORT_OCCUPIED.
REQ-012 o_retry  output  1  one-cycle pulse per ack-timeout retry; constant 0 without the macro.

Function
- REQ-013 SHALL run a 4-state FSM: IDLE, COLLECT, REQ, SEND.
- REQ-014 o_ready SHALL be 1 when state is IDLE or COLLECT and the buffer is not full; otherwise 0.
- REQ-015 Flit accept: i_flit MSB=1 and o_ready=1. An accepted flit SHALL be written to the buffer that edge. A valid flit with o_ready=0 SHALL be ignored; the sender holds it.
- REQ-016 IDLE->COLLECT on an accepted non-tail flit; IDLE->REQ on an accepted TAIL_FLIT.
- REQ-017 COLLECT->REQ on an accepted flit with flit_type TAIL_FLIT.
- REQ-018 o_downstream_req SHALL be registered and equal 1 exactly while state is REQ, first high the cycle after tail acceptance.
- REQ-019 REQ->SEND on the edge where i_transmit_ack=1. o_downstream_req SHALL drop on that same edge.
- REQ-020 SEND: o_flit SHALL be registered and equal to the buffer head with MSB=1. One pop per cycle; the first flit is valid in the cycle after the ack edge.
- REQ-021 After the tail is driven, the next cycle o_flit SHALL be invalid_flit() and state SHALL be IDLE.
- REQ-022 Outside SEND, o_flit SHALL be invalid_flit().
- REQ-023 Buffer full in COLLECT with no tail SHALL stall: o_ready=0 and the FSM holds. $error "out_id packet exceeds DEPTH" in simulation only.
- REQ-024 i_transmit_ack outside REQ SHALL be ignored.
- REQ-025 Stored flits SHALL leave in arrival order with no duplication or loss.

Reset
- REQ-026 Asserting reset, including mid-packet, SHALL asynchronously force: state IDLE, buffer empty, o_flit=invalid_flit(), o_downstream_req=0, o_retry=0, o_port_status=PORT_FREE, o_ready=1 in the first cycle after deassertion.

Configuration
- REQ-027 With OUTPUT_UNIT_TIMEOUT_EN defined, an 8-bit counter SHALL count REQ cycles without ack.
  - At ACK_TIMEOUT: o_downstream_req=0 for one cycle, o_retry pulses, counter clears, request re-asserts.
  - The packet SHALL be kept.
- REQ-028 Without OUTPUT_UNIT_TIMEOUT_EN: no counter; REQ waits for ack indefinitely; o_retry tied 0.

Structure
- REQ-029 The following SHALL live in router_pkg:
  - FLIT_t, PORT_STATUS_t, flit types, invalid_flit(), NUM_OF_FLITS, FLIT_SIZE;
  - new typedef OUT_STATE_t {IDLE, COLLECT, REQ, SEND}, exported for debug visibility.
- REQ-030 The buffer SHALL be one instance of the existing sfifo (width FLIT_SIZE, address $clog2(DEPTH)), rst_n driven by ~reset. The FSM and timeout stay in output_unit.

Verification
- REQ-031 Head, 2 body, tail on 4 consecutive cycles, ack 3 cycles after req:
  - o_downstream_req rises at cycle 4;
  - o_flit carries head, body, body, tail in the 4 cycles after the ack edge, then invalid.
- REQ-032 Single TAIL_FLIT packet from IDLE: req next cycle, 1 flit sent, back to IDLE; o_port_status returns to PORT_FREE.
- REQ-033 DEPTH=4, 5 non-tail flits offered: o_ready=0 after the 4th and the 5th is held; no buffer write; $error fires.
- REQ-034 Reset asserted in SEND after the 2nd flit: all outputs take reset values immediately. A following 3-flit packet is sent intact.
- REQ-035 With OUTPUT_UNIT_TIMEOUT_EN and ACK_TIMEOUT=16, no ack: o_retry pulses every 17 cycles. Ack given afterwards: full packet delivered.
- REQ-036 Ack pulsed in IDLE and COLLECT: no state change, o_flit stays invalid.
